// File: rtl/acc_cpu_core.sv
// Single-clock accumulator processor: fetch/decode/execute FSM, shared program/data
// memory and a step-rate tick that gates every architectural update.
module acc_cpu_core #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 5,
    parameter int STEP_DIV = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enter,
    input  logic [DATA_W-1:0] Nin,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_data,
    output logic              halt,
    output logic [DATA_W-1:0] Nout,
    output logic [2:0]        IR75out,
    output logic [3:0]        StateNoout,
    output logic [ADDR_W-1:0] pc_out,
    output logic              Aeq0,
    output logic              Apos,
    output logic              ovf
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam int CNT_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam int MSB   = DATA_W - 1;

    localparam logic [2:0] OP_LOAD  = 3'b000;
    localparam logic [2:0] OP_STORE = 3'b001;
    localparam logic [2:0] OP_ADD   = 3'b010;
    localparam logic [2:0] OP_SUB   = 3'b011;
    localparam logic [2:0] OP_IN    = 3'b100;
    localparam logic [2:0] OP_JZ    = 3'b101;
    localparam logic [2:0] OP_JPOS  = 3'b110;
    localparam logic [2:0] OP_HALT  = 3'b111;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_EXEC   = 4'd3,
        S_INWAIT = 4'd4,
        S_HALT   = 4'd5
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] ir;
    logic [ADDR_W-1:0] pc;
    logic [CNT_W-1:0]  step_cnt;
    logic              tick;
    logic              enter_q;
    logic              pending;
    logic              enter_edge;
    logic              go;
    logic [DATA_W-1:0] mem [DEPTH];

    logic [2:0]        opcode;
    logic [ADDR_W-1:0] ir_addr;
    logic [DATA_W-1:0] opnd;
    logic [DATA_W-1:0] sum;
    logic [DATA_W-1:0] diff;
    logic              add_ovf;
    logic              sub_ovf;
    logic              prog_ok;
    logic              store_now;

    assign tick       = (step_cnt == CNT_W'(STEP_DIV - 1));
    assign enter_edge = enter & ~enter_q;
    // An edge arriving on the tick clock itself is consumed immediately.
    assign go         = pending | enter_edge;

    assign opcode  = ir[DATA_W-1 -: 3];
    assign ir_addr = ir[ADDR_W-1:0];
    assign opnd    = mem[ir_addr];
    assign sum     = acc + opnd;
    assign diff    = acc - opnd;
    assign add_ovf = (acc[MSB] == opnd[MSB]) && (sum[MSB] != acc[MSB]);
    assign sub_ovf = (acc[MSB] != opnd[MSB]) && (diff[MSB] != acc[MSB]);

    assign prog_ok   = prog_we && ((state == S_IDLE) || (state == S_HALT));
    assign store_now = tick && (state == S_EXEC) && (opcode == OP_STORE);

    assign halt       = (state == S_HALT);
    assign Nout       = acc;
    assign IR75out    = opcode;
    assign StateNoout = state;
    assign pc_out     = pc;
    assign Aeq0       = (acc == '0);
    assign Apos       = (acc != '0) && !acc[MSB];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            step_cnt <= '0;
            enter_q  <= 1'b0;
            pending  <= 1'b0;
        end else begin
            step_cnt <= tick ? '0 : step_cnt + CNT_W'(1);
            enter_q  <= enter;
            if (tick)
                pending <= 1'b0;
            else if (enter_edge)
                pending <= 1'b1;
        end
    end

    // Contents survive reset so a loaded program reruns on the next enter.
    always_ff @(posedge clock) begin
        if (prog_ok)
            mem[prog_addr] <= prog_data;
        else if (store_now)
            mem[ir_addr] <= acc;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            pc    <= '0;
            acc   <= '0;
            ir    <= '0;
            ovf   <= 1'b0;
        end else if (tick) begin
            case (state)
                S_IDLE: begin
                    if (go) begin
                        ovf   <= 1'b0;
                        state <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    ir    <= mem[pc];
                    pc    <= pc + ADDR_W'(1);
                    state <= S_DECODE;
                end
                S_DECODE: begin
                    if (opcode == OP_IN)
                        state <= S_INWAIT;
                    else if (opcode == OP_HALT)
                        state <= S_HALT;
                    else
                        state <= S_EXEC;
                end
                S_EXEC: begin
                    case (opcode)
                        OP_LOAD: acc <= opnd;
                        OP_ADD: begin
                            acc <= sum;
                            if (add_ovf) ovf <= 1'b1;
                        end
                        OP_SUB: begin
                            acc <= diff;
                            if (sub_ovf) ovf <= 1'b1;
                        end
                        OP_JZ:   if (Aeq0) pc <= ir_addr;
                        OP_JPOS: if (Apos) pc <= ir_addr;
                        default: ;
                    endcase
                    state <= S_FETCH;
                end
                S_INWAIT: begin
                    if (go) begin
                        acc   <= Nin;
                        state <= S_FETCH;
                    end
                end
                S_HALT: begin
                    if (go) begin
                        pc    <= '0;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_acc_cpu_core.sv
// Bench for acc_cpu_core: directed programs plus random straight-line/forward-jump
// programs checked against an instruction-level model of the accumulator machine.
module tb_acc_cpu_core;
    logic       clock = 1'b0;
    always #5 clock = ~clock;

    logic       reset, enter, prog_we;
    logic [7:0] Nin, prog_data;
    logic [4:0] prog_addr;
    logic       halt, Aeq0, Apos, ovf;
    logic [7:0] Nout;
    logic [2:0] IR75out;
    logic [3:0] StateNoout;
    logic [4:0] pc_out;

    logic       reset4, enter4, prog_we4;
    logic       halt4, aeq4, apos4, ovf4;
    logic [7:0] nout4;
    logic [2:0] ir4;
    logic [3:0] st4;
    logic [4:0] pc4;

    acc_cpu_core #(.DATA_W(8), .ADDR_W(5), .STEP_DIV(1)) dut (
        .clock(clock), .reset(reset), .enter(enter), .Nin(Nin),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
        .halt(halt), .Nout(Nout), .IR75out(IR75out), .StateNoout(StateNoout),
        .pc_out(pc_out), .Aeq0(Aeq0), .Apos(Apos), .ovf(ovf)
    );

    acc_cpu_core #(.DATA_W(8), .ADDR_W(5), .STEP_DIV(4)) dut4 (
        .clock(clock), .reset(reset4), .enter(enter4), .Nin(Nin),
        .prog_we(prog_we4), .prog_addr(prog_addr), .prog_data(prog_data),
        .halt(halt4), .Nout(nout4), .IR75out(ir4), .StateNoout(st4),
        .pc_out(pc4), .Aeq0(aeq4), .Apos(apos4), .ovf(ovf4)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference machine state
    logic [7:0] m_mem [32];
    logic [7:0] m_a;
    logic       m_ovf;
    logic [4:0] m_pc;
    int         m_ticks;

    logic [3:0] exp_q[$];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    // Runs the program in m_mem from address 0 one instruction at a time.
    task automatic model_run();
        logic [7:0] w, opnd;
        logic [4:0] ad;
        int s;
        int steps;
        m_ovf = 1'b0; m_pc = 5'd0; m_ticks = 1; steps = 0;
        while (steps < 500) begin
            w = m_mem[m_pc]; ad = w[4:0]; opnd = m_mem[ad];
            m_pc = m_pc + 5'd1;
            steps++;
            if (w[7:5] == 3'b111) begin
                m_ticks += 2;
                return;
            end
            m_ticks += 3;
            case (w[7:5])
                3'b000: m_a = opnd;
                3'b001: m_mem[ad] = m_a;
                3'b010: begin
                    s = int'($signed(m_a)) + int'($signed(opnd));
                    if (s > 127 || s < -128) m_ovf = 1'b1;
                    m_a = m_a + opnd;
                end
                3'b011: begin
                    s = int'($signed(m_a)) - int'($signed(opnd));
                    if (s > 127 || s < -128) m_ovf = 1'b1;
                    m_a = m_a - opnd;
                end
                3'b101: if (m_a == 8'd0) m_pc = ad;
                3'b110: if ($signed(m_a) > 0) m_pc = ad;
                default: ;
            endcase
        end
    endtask

    task automatic prog_write(input int a, input logic [7:0] d);
        @(negedge clock);
        prog_we = 1'b1; prog_addr = a[4:0]; prog_data = d;
        @(negedge clock);
        prog_we = 1'b0;
        m_mem[a] = d;
    endtask

    task automatic prog_write4(input int a, input logic [7:0] d);
        @(negedge clock);
        prog_we4 = 1'b1; prog_addr = a[4:0]; prog_data = d;
        @(negedge clock);
        prog_we4 = 1'b0;
    endtask

    task automatic ensure_idle();
        if (halt) begin
            @(negedge clock); enter = 1'b1;
            @(negedge clock); enter = 1'b0;
            check_val("halt_to_idle", StateNoout, 0);
        end
    endtask

    task automatic run_dut(input int budget, output int ticks);
        @(negedge clock);
        enter = 1'b1;
        ticks = 0;
        while (ticks < budget) begin
            @(posedge clock); #1;
            enter = 1'b0;
            ticks++;
            if (halt) break;
        end
        if (!halt) check_val("halt_timeout", halt, 1);
    endtask

    task automatic run_check(input string tag, output int ticks);
        ensure_idle();
        model_run();
        run_dut(600, ticks);
        check_val({tag, "_ticks"}, ticks, m_ticks);
        check_val({tag, "_nout"}, Nout, m_a);
        check_val({tag, "_ovf"}, ovf, m_ovf);
        check_val({tag, "_pc"}, pc_out, m_pc);
        check_val({tag, "_aeq0"}, Aeq0, m_a == 8'd0);
        check_val({tag, "_apos"}, Apos, $signed(m_a) > 0);
    endtask

    task automatic step4(input logic pulse, input logic [3:0] s);
        @(negedge clock);
        enter4 = pulse;
        for (int k = 0; k < 40; k++) begin
            @(posedge clock); #1;
            enter4 = 1'b0;
            if (st4 == s) break;
        end
        if (st4 != s) check_val("wait4_timeout", st4, s);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int t, len, op, prev, last_k, n_chg;
        logic [2:0] code;
        logic [4:0] ad;

        reset = 1'b0; reset4 = 1'b0; enter = 1'b0; enter4 = 1'b0;
        Nin = 8'd0; prog_we = 1'b0; prog_we4 = 1'b0; prog_addr = 5'd0; prog_data = 8'd0;
        m_a = 8'd0;
        repeat (3) @(negedge clock);
        check_val("rst_nout", Nout, 0);
        check_val("rst_aeq0", Aeq0, 1);
        check_val("rst_apos", Apos, 0);
        check_val("rst_state", StateNoout, 0);
        check_val("rst_halt", halt, 0);
        check_val("rst_pc", pc_out, 0);
        check_val("rst_ovf", ovf, 0);
        check_val("rst_ir", IR75out, 0);
        check_val("rst4_state", st4, 0);
        reset = 1'b1; reset4 = 1'b1;

        // LOAD 10, ADD 11, STORE 12, HALT
        prog_write(0, 8'h0A); prog_write(1, 8'h4B); prog_write(2, 8'h2C); prog_write(3, 8'hE0);
        prog_write(10, 8'd5); prog_write(11, 8'd7);
        run_check("addprog", t);
        check_val("addprog_12ticks", t, 12);
        check_val("addprog_12", Nout, 12);
        check_val("addprog_ir", IR75out, 3'b111);
        prog_write(0, 8'h0C); prog_write(1, 8'hE0);
        run_check("readback12", t);
        check_val("readback12_val", Nout, 12);

        // IN then HALT; machine parks in INWAIT until enter
        prog_write(0, 8'h80); prog_write(1, 8'hE0);
        ensure_idle();
        @(negedge clock); enter = 1'b1;
        @(negedge clock); enter = 1'b0;
        repeat (2) @(negedge clock);
        check_val("inwait_enter", StateNoout, 4);
        repeat (20) @(negedge clock);
        check_val("inwait_hold", StateNoout, 4);
        check_val("inwait_nohalt", halt, 0);
        Nin = 8'h33;
        run_dut(10, t);
        check_val("in_ticks", t, 3);
        check_val("in_nout", Nout, 8'h33);
        check_val("in_pc", pc_out, 2);
        m_a = 8'h33;

        // Countdown loop: LOAD 20, SUB 21, JPOS 1, HALT
        prog_write(0, 8'h14); prog_write(1, 8'h75); prog_write(2, 8'hC1); prog_write(3, 8'hE0);
        prog_write(20, 8'd3); prog_write(21, 8'd1);
        run_check("countdown", t);
        check_val("countdown_24ticks", t, 24);
        check_val("countdown_zero", Nout, 0);
        check_val("countdown_aeq0", Aeq0, 1);

        // Signed overflow is sticky through a later ADD 0 and cleared by a new run
        prog_write(0, 8'h14); prog_write(1, 8'h55); prog_write(2, 8'h56); prog_write(3, 8'hE0);
        prog_write(20, 8'h7F); prog_write(21, 8'h01); prog_write(22, 8'h00);
        run_check("ovfprog", t);
        check_val("ovfprog_nout", Nout, 8'h80);
        check_val("ovfprog_ovf", ovf, 1);
        ensure_idle();
        check_val("ovf_idle_kept", ovf, 1);
        prog_write(0, 8'hE0);
        run_check("ovf_restart", t);
        check_val("ovf_cleared", ovf, 0);
        check_val("a_preserved", Nout, 8'h80);

        for (int r = 0; r < 8; r++) begin
            len = $urandom_range(3, 10);
            for (int i = 0; i < len; i++) begin
                op = $urandom_range(0, 5);
                code = (op < 4) ? 3'(op) : 3'(op + 1);
                ad = (op >= 4) ? 5'($urandom_range(i + 1, len)) : 5'($urandom_range(16, 31));
                prog_write(i, {code, ad});
            end
            prog_write(len, 8'hE0);
            for (int a = 16; a < 32; a++) prog_write(a, 8'($urandom_range(0, 255)));
            run_check($sformatf("rnd%0d", r), t);
            for (int j = 0; j < 2; j++) begin
                ad = 5'($urandom_range(16, 31));
                prog_write(0, {3'b000, ad}); prog_write(1, 8'hE0);
                run_check($sformatf("rnd%0d_mem%0d", r, ad), t);
            end
        end

        // Step-rate instance: LOAD 10, HALT with M10 = 0x5A
        prog_write4(0, 8'h0A); prog_write4(1, 8'hE0); prog_write4(10, 8'h5A);
        exp_q = '{4'd1, 4'd2, 4'd3, 4'd1, 4'd2, 4'd5};
        @(negedge clock);
        enter4 = 1'b1; prev = int'(st4); last_k = -1; n_chg = 0;
        for (int k = 0; k < 60; k++) begin
            @(posedge clock); #1;
            enter4 = 1'b0;
            if (int'(st4) != prev) begin
                n_chg++;
                if (exp_q.size() > 0) check_val("step4_state", st4, exp_q.pop_front());
                if (last_k >= 0) check_val("step4_spacing", k - last_k, 4);
                last_k = k; prev = int'(st4);
            end
            if (halt4) break;
        end
        check_val("step4_changes", n_chg, 6);
        check_val("step4_nout", nout4, 8'h5A);

        step4(1'b1, 4'd0);
        step4(1'b1, 4'd1);
        prog_we4 = 1'b1; prog_addr = 5'd10; prog_data = 8'h11;
        @(posedge clock); #1;
        prog_we4 = 1'b0;
        check_val("fetch_we_state", st4, 1);
        step4(1'b0, 4'd5);
        check_val("fetch_we_ignored", nout4, 8'h5A);

        step4(1'b1, 4'd0);
        step4(1'b1, 4'd3);
        reset4 = 1'b0;
        #1;
        check_val("exec_rst_state", st4, 0);
        check_val("exec_rst_pc", pc4, 0);
        check_val("exec_rst_nout", nout4, 0);
        check_val("exec_rst_ovf", ovf4, 0);
        @(negedge clock);
        reset4 = 1'b1;
        step4(1'b1, 4'd5);
        check_val("rerun_after_rst", nout4, 8'h5A);
        check_val("rerun_halt", halt4, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
